// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types, constants and helpers for instr_fetch_unit.
// Perf counters are built only when IFU_PERF_CNT_EN is defined.
package ifu_pkg;

  typedef enum logic {
    S_REQ,
    S_PARK
  } ifu_state_e;

  localparam logic [31:0] WORD_BYTES    = 32'd4;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/ifu_imem_if.sv
// ifu_imem_if: request/acknowledge instruction-memory port.
// master = fetch unit, slave = instruction memory.
interface ifu_imem_if;

  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRdata;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemRdata
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemRdata
  );

endinterface

// File: rtl/ifu_redirect_sel.sv
// ifu_redirect_sel: picks the redirect target among jump,
// branch and a parked redirect, word-aligned.
module ifu_redirect_sel
  import ifu_pkg::*;
(
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        pend_valid_i,
  input  logic [31:0] pend_target_i,
  output logic        now_o,
  output logic        redir_o,
  output logic [31:0] target_o
);

  assign now_o   = jump_i | branch_i;
  assign redir_o = now_o | pend_valid_i;

  // Jump beats branch; a live redirect beats a parked one.
  always_comb begin
    target_o = '0;
    priority case (1'b1)
      jump_i:       target_o = word_align(jump_target_i);
      branch_i:     target_o = word_align(branch_target_i);
      pend_valid_i: target_o = pend_target_i;
      default:      target_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, imem request FSM, skid and IF/ID feed.
// Define IFU_PERF_CNT_EN to build the perf counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  ifu_imem_if.master  imem,
  output logic [31:0] NewPCAddress,
  output logic [31:0] Instruction,
  output logic        FetchValid,
  output logic [31:0] PerfFetched,
  output logic [31:0] PerfBubbles
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_t_q, pend_t_d;
  logic [31:0] skid_ins_q, skid_ins_d;
  logic [31:0] skid_npc_q, skid_npc_d;
  logic [31:0] out_ins_q, out_ins_d;
  logic [31:0] out_npc_q, out_npc_d;
  logic        out_v_q, out_v_d;

  logic        redir_now;
  logic        redir_any;
  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        load_v;
  logic        bubble;

  ifu_redirect_sel u_sel (
    .jump_i          (Jump),
    .jump_target_i   (JumpTarget),
    .branch_i        (BranchTaken),
    .branch_target_i (BranchTarget),
    .pend_valid_i    (pend_v_q),
    .pend_target_i   (pend_t_q),
    .now_o           (redir_now),
    .redir_o         (redir_any),
    .target_o        (tgt)
  );

  assign pc_inc        = pc_q + WORD_BYTES;
  assign imem.IMemReq  = (state_q == S_REQ);
  assign imem.IMemAddr = pc_q;

  assign NewPCAddress = out_npc_q;
  assign Instruction  = out_ins_q;
  assign FetchValid   = out_v_q;

  // Next-state: request/park FSM, PC, pending, skid, outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_t_d   = pend_t_q;
    skid_ins_d = skid_ins_q;
    skid_npc_d = skid_npc_q;
    out_ins_d  = out_ins_q;
    out_npc_d  = out_npc_q;
    out_v_d    = out_v_q;
    load_v     = 1'b0;
    bubble     = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (!imem.IMemAck) begin
          if (redir_now) begin
            pend_v_d = 1'b1;
            pend_t_d = tgt;
            bubble   = 1'b1;
          end else if (!Stall) begin
            bubble = 1'b1;
          end
        end else if (redir_any) begin
          pc_d     = tgt;
          pend_v_d = 1'b0;
          bubble   = 1'b1;
        end else begin
          pc_d = pc_inc;
          if (Stall) begin
            skid_ins_d = imem.IMemRdata;
            skid_npc_d = pc_inc;
            state_d    = S_PARK;
          end else begin
            out_ins_d = imem.IMemRdata;
            out_npc_d = pc_inc;
            load_v    = 1'b1;
          end
        end
      end
      S_PARK: begin
        if (redir_now) begin
          pc_d       = tgt;
          skid_ins_d = '0;
          skid_npc_d = '0;
          bubble     = 1'b1;
          state_d    = S_REQ;
        end else if (!Stall) begin
          out_ins_d = skid_ins_q;
          out_npc_d = skid_npc_q;
          load_v    = 1'b1;
          state_d   = S_REQ;
        end
      end
    endcase
    if (bubble) begin
      out_v_d   = 1'b0;
      out_ins_d = NOP_INSTR;
    end
    if (load_v) begin
      out_v_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_t_q   <= '0;
      skid_ins_q <= '0;
      skid_npc_q <= '0;
      out_ins_q  <= NOP_INSTR;
      out_npc_q  <= '0;
      out_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_t_q   <= pend_t_d;
      skid_ins_q <= skid_ins_d;
      skid_npc_q <= skid_npc_d;
      out_ins_q  <= out_ins_d;
      out_npc_q  <= out_npc_d;
      out_v_q    <= out_v_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] bubbles_q;

  // Count delivered instructions and unstalled bubble cycles.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (load_v) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (!Stall && !out_v_q) begin
        bubbles_q <= bubbles_q + 32'd1;
      end
    end
  end

  assign PerfFetched = fetched_q;
  assign PerfBubbles = bubbles_q;
`else
  assign PerfFetched = '0;
  assign PerfBubbles = '0;
`endif

endmodule
